// File: rtl/rx_pkt_queue_manager.sv
// Per-queue RX ring-buffer bookkeeping ahead of the FPGA-to-CPU DMA engine.
// Decides accept/drop from free ring space, advances tails, and annotates metadata for DMA.
module rx_pkt_queue_manager #(
    parameter int NB_QUEUES = 16,
    parameter int QID_W     = 4,
    parameter int RB_AWIDTH = 16,
    parameter int SIZE_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_reset,
    input  logic [RB_AWIDTH:0]   rb_size,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QID_W-1:0]     in_queue_id,
    input  logic [SIZE_W-1:0]    in_size,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QID_W-1:0]     out_queue_id,
    output logic [SIZE_W-1:0]    out_size,
    output logic [63:0]          out_kmem_addr,
    output logic [RB_AWIDTH-1:0] out_tail,
    output logic                 out_drop,
    input  logic                 cfg_addr_wr,
    input  logic                 cfg_head_wr,
    input  logic [QID_W-1:0]     cfg_queue_id,
    input  logic [63:0]          cfg_kmem_addr,
    input  logic [RB_AWIDTH-1:0] cfg_head,
    output logic [31:0]          drop_cnt
);
    localparam int CMP_W = (SIZE_W > RB_AWIDTH) ? SIZE_W : RB_AWIDTH;

    logic [63:0]          kmem_addr_r [NB_QUEUES];
    logic [RB_AWIDTH-1:0] head_r      [NB_QUEUES];
    logic [RB_AWIDTH-1:0] tail_r      [NB_QUEUES];

    logic                 out_valid_r;
    logic [QID_W-1:0]     out_queue_id_r;
    logic [SIZE_W-1:0]    out_size_r;
    logic [63:0]          out_kmem_addr_r;
    logic [RB_AWIDTH-1:0] out_tail_r;
    logic                 out_drop_r;
    logic [31:0]          drop_cnt_r;

    logic [RB_AWIDTH:0]   mask_wide_s;
    logic [RB_AWIDTH-1:0] mask_s;
    logic [63:0]          cur_addr_s;
    logic [RB_AWIDTH-1:0] cur_head_s;
    logic [RB_AWIDTH-1:0] cur_tail_s;
    logic [RB_AWIDTH-1:0] free_s;
    logic [RB_AWIDTH-1:0] next_tail_s;
    logic [CMP_W-1:0]     size_cmp_s;
    logic [CMP_W-1:0]     free_cmp_s;
    logic [CMP_W-1:0]     sum_s;
    logic                 cfg_hit_s;
    logic                 accept_s;
    logic                 drop_s;

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Free-space check and tail advance for the queue addressed by the incoming packet
    always_comb begin
        mask_wide_s = rb_size - {{RB_AWIDTH{1'b0}}, 1'b1};
        // An illegal rb_size of zero degrades to the full index range
        mask_s      = mask_wide_s[RB_AWIDTH-1:0] | {RB_AWIDTH{mask_wide_s[RB_AWIDTH]}};
        cur_addr_s  = kmem_addr_r[in_queue_id];
        cur_head_s  = head_r[in_queue_id];
        cur_tail_s  = tail_r[in_queue_id];
        free_s      = (cur_head_s - cur_tail_s - RB_AWIDTH'(1)) & mask_s;
        size_cmp_s  = CMP_W'(in_size);
        free_cmp_s  = CMP_W'(free_s);
        sum_s       = CMP_W'(cur_tail_s) + size_cmp_s;
        next_tail_s = sum_s[RB_AWIDTH-1:0] & mask_s;
        cfg_hit_s   = cfg_addr_wr && (cfg_queue_id == in_queue_id);
        drop_s      = (cur_addr_s == 64'd0) || (in_size == SIZE_W'(0)) ||
                      (size_cmp_s > free_cmp_s) || cfg_hit_s;
    end

    // Queue table: base-address rewrite resets the ring and overrides head write and tail advance
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < NB_QUEUES; q++) begin
                kmem_addr_r[q] <= 64'd0;
                head_r[q]      <= {RB_AWIDTH{1'b0}};
                tail_r[q]      <= {RB_AWIDTH{1'b0}};
            end
        end else begin
            for (int q = 0; q < NB_QUEUES; q++) begin
                if (cfg_addr_wr && (cfg_queue_id == QID_W'(q))) begin
                    kmem_addr_r[q] <= cfg_kmem_addr;
                    head_r[q]      <= {RB_AWIDTH{1'b0}};
                    tail_r[q]      <= {RB_AWIDTH{1'b0}};
                end else begin
                    if (cfg_head_wr && (cfg_queue_id == QID_W'(q))) begin
                        head_r[q] <= cfg_head & mask_s;
                    end
                    if (accept_s && !drop_s && (in_queue_id == QID_W'(q))) begin
                        tail_r[q] <= next_tail_s;
                    end
                end
            end
        end
    end

    // Output register stage, held while the downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r     <= 1'b0;
            out_queue_id_r  <= {QID_W{1'b0}};
            out_size_r      <= {SIZE_W{1'b0}};
            out_kmem_addr_r <= 64'd0;
            out_tail_r      <= {RB_AWIDTH{1'b0}};
            out_drop_r      <= 1'b0;
        end else if (in_ready) begin
            out_valid_r <= in_valid;
            if (accept_s) begin
                out_queue_id_r  <= in_queue_id;
                out_size_r      <= in_size;
                out_kmem_addr_r <= cur_addr_s;
                out_tail_r      <= cur_tail_s;
                out_drop_r      <= drop_s;
            end
        end
    end

    // Saturating drop counter with software clear
    always_ff @(posedge clk) begin
        if (rst || sw_reset) begin
            drop_cnt_r <= 32'd0;
        end else if (accept_s && drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
            drop_cnt_r <= drop_cnt_r + 32'd1;
        end
    end

    assign out_valid     = out_valid_r;
    assign out_queue_id  = out_queue_id_r;
    assign out_size      = out_size_r;
    assign out_kmem_addr = out_kmem_addr_r;
    assign out_tail      = out_tail_r;
    assign out_drop      = out_drop_r;
    assign drop_cnt      = drop_cnt_r;
endmodule

// File: tb/tb_rx_pkt_queue_manager.sv
// Self-checking bench for rx_pkt_queue_manager: directed ring scenarios plus random traffic
// compared against a modulo-arithmetic reference model of the queue table.
module tb_rx_pkt_queue_manager;
    localparam int NQ = 16;
    localparam int QW = 4;
    localparam int AW = 16;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst, sw_reset;
    logic [AW:0]   rb_size;
    logic          in_valid, in_ready;
    logic [QW-1:0] in_queue_id;
    logic [SW-1:0] in_size;
    logic          out_valid, out_ready;
    logic [QW-1:0] out_queue_id;
    logic [SW-1:0] out_size;
    logic [63:0]   out_kmem_addr;
    logic [AW-1:0] out_tail;
    logic          out_drop;
    logic          cfg_addr_wr, cfg_head_wr;
    logic [QW-1:0] cfg_queue_id;
    logic [63:0]   cfg_kmem_addr;
    logic [AW-1:0] cfg_head;
    logic [31:0]   drop_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] m_addr [NQ];
    int          m_head [NQ];
    int          m_tail [NQ];
    bit          m_ov;
    int          m_qid, m_size, m_otail;
    logic [63:0] m_oaddr;
    bit          m_drop;
    longint      m_cnt;

    rx_pkt_queue_manager dut (
        .clk(clk), .rst(rst), .sw_reset(sw_reset), .rb_size(rb_size),
        .in_valid(in_valid), .in_ready(in_ready), .in_queue_id(in_queue_id), .in_size(in_size),
        .out_valid(out_valid), .out_ready(out_ready), .out_queue_id(out_queue_id),
        .out_size(out_size), .out_kmem_addr(out_kmem_addr), .out_tail(out_tail),
        .out_drop(out_drop), .cfg_addr_wr(cfg_addr_wr), .cfg_head_wr(cfg_head_wr),
        .cfg_queue_id(cfg_queue_id), .cfg_kmem_addr(cfg_kmem_addr), .cfg_head(cfg_head),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; sw_reset = 1'b0; in_valid = 1'b0; in_queue_id = 4'd0; in_size = 16'd0;
        out_ready = 1'b1; cfg_addr_wr = 1'b0; cfg_head_wr = 1'b0; cfg_queue_id = 4'd0;
        cfg_kmem_addr = 64'd0; cfg_head = 16'd0;
    endtask

    // One clock: check in_ready mid-cycle, step the model, check outputs after the edge
    task automatic cycle();
        bit rdy, acc, drp;
        int rb, q, fr, cq;
        #4;
        rdy = !m_ov || (out_ready == 1'b1);
        if (!rst) check_val("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        acc = (in_valid == 1'b1) && rdy;
        rb  = int'(rb_size);
        q   = int'(in_queue_id);
        cq  = int'(cfg_queue_id);
        if (rst) begin
            for (int i = 0; i < NQ; i++) begin
                m_addr[i] = 64'd0; m_head[i] = 0; m_tail[i] = 0;
            end
            m_ov = 1'b0; m_qid = 0; m_size = 0; m_otail = 0; m_oaddr = 64'd0; m_drop = 1'b0;
            m_cnt = 0;
        end else begin
            if (acc) begin
                fr  = (((m_head[q] - m_tail[q] - 1) % rb) + rb) % rb;
                drp = (m_addr[q] == 64'd0) || (in_size == 16'd0) || (int'(in_size) > fr) ||
                      ((cfg_addr_wr == 1'b1) && (cq == q));
                m_qid = q; m_size = int'(in_size); m_oaddr = m_addr[q];
                m_otail = m_tail[q]; m_drop = drp;
                if (!drp) m_tail[q] = (m_tail[q] + int'(in_size)) % rb;
                if (drp && m_cnt != 64'hFFFF_FFFF) m_cnt++;
            end
            if (rdy) m_ov = (in_valid == 1'b1);
            if (cfg_addr_wr) begin
                m_addr[cq] = cfg_kmem_addr; m_head[cq] = 0; m_tail[cq] = 0;
            end else if (cfg_head_wr) begin
                m_head[cq] = int'(cfg_head) % rb;
            end
            if (sw_reset) m_cnt = 0;
        end
        @(posedge clk);
        #1;
        check_val("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        check_val("drop_cnt", {32'd0, drop_cnt}, m_cnt);
        if (m_ov) begin
            check_val("out_queue_id", {60'd0, out_queue_id}, m_qid);
            check_val("out_size", {48'd0, out_size}, m_size);
            check_val("out_kmem_addr", out_kmem_addr, m_oaddr);
            check_val("out_tail", {48'd0, out_tail}, m_otail);
            check_val("out_drop", {63'd0, out_drop}, {63'd0, m_drop});
        end
    endtask

    task automatic pkt(input int q, input int s);
        in_valid = 1'b1; in_queue_id = q[3:0]; in_size = s[15:0];
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic set_addr(input int q, input logic [63:0] a);
        cfg_addr_wr = 1'b1; cfg_queue_id = q[3:0]; cfg_kmem_addr = a;
        cycle();
        cfg_addr_wr = 1'b0;
    endtask

    task automatic set_head(input int q, input int h);
        cfg_head_wr = 1'b1; cfg_queue_id = q[3:0]; cfg_head = h[15:0];
        cycle();
        cfg_head_wr = 1'b0;
    endtask

    initial begin
        int rbs [3];
        rbs[0] = 4; rbs[1] = 16; rbs[2] = 64;
        idle();
        rb_size = 17'd16;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("reset_out_tail", {48'd0, out_tail}, 64'd0);
        check_val("reset_kmem", out_kmem_addr, 64'd0);
        cycle();

        // Sequential packets on q0, then wrap and full-ring drop
        set_addr(0, 64'h1000);
        pkt(0, 3);  check_val("s1_tail_a", {48'd0, out_tail}, 64'd0);
        pkt(0, 4);  check_val("s1_tail_b", {48'd0, out_tail}, 64'd3);
        pkt(0, 5);  check_val("s1_tail_c", {48'd0, out_tail}, 64'd7);
        pkt(0, 3);  check_val("s2_accept", {63'd0, out_drop}, 64'd0);
        pkt(0, 1);  check_val("s2_full_drop", {63'd0, out_drop}, 64'd1);
        check_val("s2_drop_cnt", {32'd0, drop_cnt}, 64'd1);

        // Wrap across the ring end on q1
        set_addr(1, 64'h2000);
        pkt(1, 14);
        set_head(1, 4);
        pkt(1, 4);  check_val("s3_tail", {48'd0, out_tail}, 64'd14);
        pkt(1, 1);  check_val("s3_wrapped", {48'd0, out_tail}, 64'd2);

        // Downstream stall then release at full rate
        set_head(1, 3);
        pkt(1, 1);
        in_valid = 1'b1; in_queue_id = 4'd1; in_size = 16'd1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        in_valid = 1'b0;
        cycle();

        // Unconfigured queue and config collision
        pkt(2, 2);  check_val("s5_noaddr_drop", {63'd0, out_drop}, 64'd1);
        in_valid = 1'b1; in_queue_id = 4'd2; in_size = 16'd2;
        set_addr(2, 64'h3000);
        check_val("s5_collide_drop", {63'd0, out_drop}, 64'd1);
        pkt(2, 2);  check_val("s5_after_cfg_tail", {48'd0, out_tail}, 64'd0);

        // Counter clear and reset during a stall
        sw_reset = 1'b1; cycle(); sw_reset = 1'b0;
        check_val("sw_reset_cnt", {32'd0, drop_cnt}, 64'd0);
        in_valid = 1'b1; in_queue_id = 4'd2; in_size = 16'd1; out_ready = 1'b0;
        cycle(); cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        check_val("rst_mid_stall", {63'd0, out_valid}, 64'd0);
        idle();
        cycle();

        // Random traffic at several ring sizes
        for (int p = 0; p < 3; p++) begin
            rb_size = rbs[p][16:0];
            for (int q = 0; q < 4; q++) set_addr(q, 64'h10000 * (q + 1));
            for (int n = 0; n < 600; n++) begin
                rst           = ($urandom % 400) == 0;
                sw_reset      = ($urandom % 50) == 0;
                in_valid      = ($urandom % 4) != 0;
                in_queue_id   = 4'($urandom % 4);
                in_size       = 16'($urandom % (rbs[p] / 2 + 2));
                out_ready     = ($urandom % 4) != 0;
                cfg_head_wr   = ($urandom % 6) == 0;
                cfg_head      = 16'($urandom);
                cfg_addr_wr   = ($urandom % 25) == 0;
                cfg_queue_id  = 4'($urandom % 4);
                cfg_kmem_addr = (($urandom % 4) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
                cycle();
            end
            idle();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
